// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the byte-serial memory controller to instruction fetch or the load/store buffer.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed LSB priority with anti-starvation.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              RoB_clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [2:0]        ls_len,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_value,
  output logic              ls_done,
  output logic [31:0]       ls_data,
  output logic              mc_waiting,
  output logic              mc_wr,
  output logic [2:0]        mc_len,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [31:0]       mc_value,
  input  logic              mc_ready,
  input  logic [31:0]       mc_result
);

  localparam logic [2:0] IF_LEN = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                mc_wr_q, mc_wr_d;
  logic [2:0]          mc_len_q, mc_len_d;
  logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;
  logic [31:0]         mc_value_q, mc_value_d;
  logic                if_done_q, if_done_d;
  logic                ls_done_q, ls_done_d;
  logic [31:0]         if_data_q, if_data_d;
  logic [31:0]         ls_data_q, ls_data_d;

  logic                arb_open;
  logic                grant_if;
  logic                grant_ls;

  // No arbitration while a done pulse is showing, so a finishing requester is never re-granted on stale req.
  assign arb_open = (state_q == S_IDLE) && !if_done_q && !ls_done_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t last_q, last_d;

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (arb_open) begin
      if (if_req && ls_req) begin
        grant_if = (last_q == OWN_LS);
        grant_ls = (last_q == OWN_IF);
      end else begin
        grant_if = if_req;
        grant_ls = ls_req;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (!RoB_clear) begin
      if (grant_if) begin
        last_d = OWN_IF;
      end else if (grant_ls) begin
        last_d = OWN_LS;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_q <= OWN_IF;
    end else if (rdy_in || RoB_clear) begin
      last_q <= last_d;
    end
  end
`else
  localparam int unsigned STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                if_forced;

  assign if_forced = (starve_q >= STARVE_LIM);

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (arb_open) begin
      grant_if = if_req && (!ls_req || if_forced);
      grant_ls = ls_req && !grant_if;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_ls && if_req && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
    if (RoB_clear) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      starve_q <= '0;
    end else if (rdy_in || RoB_clear) begin
      starve_q <= starve_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    mc_wr_d    = mc_wr_q;
    mc_len_d   = mc_len_q;
    mc_addr_d  = mc_addr_q;
    mc_value_d = mc_value_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_data_d  = ls_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (grant_ls) begin
          owner_d    = OWN_LS;
          mc_wr_d    = ls_wr;
          mc_len_d   = ls_len;
          mc_addr_d  = ls_addr;
          mc_value_d = ls_value;
          state_d    = S_ISSUE;
        end else if (grant_if) begin
          owner_d    = OWN_IF;
          mc_wr_d    = 1'b0;
          mc_len_d   = IF_LEN;
          mc_addr_d  = if_addr;
          mc_value_d = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mc_ready) begin
          if (owner_q == OWN_IF) begin
            if_data_d = mc_result;
            if_done_d = 1'b1;
          end else begin
            ls_data_d = mc_result;
            ls_done_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush overrides everything computed above, including a same-cycle grant or completion.
    if (RoB_clear) begin
      state_d    = S_IDLE;
      owner_d    = owner_q;
      mc_wr_d    = mc_wr_q;
      mc_len_d   = mc_len_q;
      mc_addr_d  = mc_addr_q;
      mc_value_d = mc_value_q;
      if_done_d  = 1'b0;
      ls_done_d  = 1'b0;
      if_data_d  = if_data_q;
      ls_data_d  = ls_data_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      mc_wr_q    <= 1'b0;
      mc_len_q   <= '0;
      mc_addr_q  <= '0;
      mc_value_q <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_data_q  <= '0;
    end else if (rdy_in || RoB_clear) begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      mc_wr_q    <= mc_wr_d;
      mc_len_q   <= mc_len_d;
      mc_addr_q  <= mc_addr_d;
      mc_value_q <= mc_value_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_data_q  <= ls_data_d;
    end
  end

  assign mc_waiting = (state_q != S_IDLE);
  assign mc_wr      = mc_wr_q;
  assign mc_len     = mc_len_q;
  assign mc_addr    = mc_addr_q;
  assign mc_value   = mc_value_q;
  assign if_done    = if_done_q;
  assign if_data    = if_data_q;
  assign ls_done    = ls_done_q;
  assign ls_data    = ls_data_q;

endmodule
